// File: rtl/libhdl_fifo_pkt.sv
`default_nettype none
// libhdl_fifo_pkt: common-clock packet FIFO; beats become readable only once the packet's last beat commits.
// Optional oversize-packet discard is enabled by defining LIBHDL_FIFO_PKT_DROP_EN.
module libhdl_fifo_pkt #(
  parameter  int DATA_LEN         = 32,
  parameter  int DEPTH            = 16,
  parameter  int ALMOST_EMPTY_CNT = DEPTH / 4,
  parameter  int ALMOST_FULL_CNT  = DEPTH - DEPTH / 4,
  localparam int AW               = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  output logic                o_wrdy,
  input  logic                i_wvld,
  input  logic [DATA_LEN-1:0] i_wdat,
  input  logic                i_wlast,
  input  logic                i_wdrop,
  output logic                o_wfull,
  output logic                o_walmost_full,
  output logic [AW:0]         o_wcount,
  output logic                o_werr,
  input  logic                i_rrdy,
  output logic                o_rvld,
  output logic [DATA_LEN-1:0] o_rdat,
  output logic                o_rlast,
  output logic                o_rempty,
  output logic                o_ralmost_empty,
  output logic [AW:0]         o_rcount,
  output logic [AW:0]         o_pkt_cnt
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AE_W    = (AW + 1)'(ALMOST_EMPTY_CNT);
  localparam logic [AW:0] AF_W    = (AW + 1)'(ALMOST_FULL_CNT);

  logic [DATA_LEN:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, commit_ptr, rd_ptr, pkt_cnt;
  logic [AW:0]       wr_ptr_nxt, wcount, rcount;
  logic              full, wr_acc, rd_acc, rd_last, store, commit, bypass;

  assign wcount  = wr_ptr - rd_ptr;
  assign rcount  = commit_ptr - rd_ptr;
  assign full    = (wcount == DEPTH_W);
  assign rd_last = mem[rd_ptr[AW-1:0]][DATA_LEN];
  assign wr_acc  = i_wvld && o_wrdy;
  assign rd_acc  = o_rvld && i_rrdy;

`ifdef LIBHDL_FIFO_PKT_DROP_EN
  typedef enum logic {W_PASS = 1'b0, W_DISCARD = 1'b1} wstate_t;
  wstate_t state, state_nxt;
  logic    overflow, werr, werr_nxt;

  // Storage holds nothing but one unfinished packet: it can never commit, so swallow the rest.
  assign overflow = full && (commit_ptr == rd_ptr);
  assign bypass   = overflow || (state == W_DISCARD);
  assign o_wrdy   = !i_rst && (!full || bypass);
  assign o_werr   = werr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= W_PASS;
      werr  <= 1'b0;
    end else begin
      state <= state_nxt;
      werr  <= werr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    werr_nxt  = 1'b0;
    case (state)
      W_PASS: begin
        if (overflow && !i_wdrop) begin
          if (wr_acc && i_wlast) werr_nxt = 1'b1;
          else                   state_nxt = W_DISCARD;
        end
      end
      W_DISCARD: begin
        if (i_wdrop) begin
          state_nxt = W_PASS;
        end else if (wr_acc && i_wlast) begin
          werr_nxt  = 1'b1;
          state_nxt = W_PASS;
        end
      end
      default: state_nxt = W_PASS;
    endcase
  end
`else
  assign bypass = 1'b0;
  assign o_wrdy = !i_rst && !full;
  assign o_werr = 1'b0;
`endif

  // A drop or a discarded beat rewinds the speculative pointer to the last commit.
  always_comb begin
    store      = wr_acc && !i_wdrop && !bypass;
    commit     = store && i_wlast;
    wr_ptr_nxt = wr_ptr;
    if (i_wdrop || bypass) wr_ptr_nxt = commit_ptr;
    else if (store)        wr_ptr_nxt = wr_ptr + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      if (commit) commit_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({commit, rd_acc && rd_last})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (store) mem[wr_ptr[AW-1:0]] <= {i_wlast, i_wdat};
  end

  assign o_rvld          = (rd_ptr != commit_ptr);
  assign o_rdat          = mem[rd_ptr[AW-1:0]][DATA_LEN-1:0];
  assign o_rlast         = rd_last;
  assign o_wfull         = full;
  assign o_walmost_full  = (wcount >= AF_W);
  assign o_wcount        = wcount;
  assign o_rempty        = (rcount == '0);
  assign o_ralmost_empty = (rcount <= AE_W);
  assign o_rcount        = rcount;
  assign o_pkt_cnt       = pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_libhdl_fifo_pkt.sv
`default_nettype none
// tb_libhdl_fifo_pkt: directed + random stimulus against a queue-based packet FIFO model.
module tb_libhdl_fifo_pkt;
  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int AW  = 4;
  localparam int AEC = DEP / 4;
  localparam int AFC = DEP - DEP / 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wvld = 1'b0, wlast = 1'b0, wdrop = 1'b0, rrdy = 1'b0;
  logic [DW-1:0] wdat = '0;
  logic          o_wrdy, o_wfull, o_walmost_full, o_werr, o_rvld, o_rlast, o_rempty, o_ralmost_empty;
  logic [AW:0]   o_wcount, o_rcount, o_pkt_cnt;
  logic [DW-1:0] o_rdat;

  int checks = 0;
  int errors = 0;

  // Model: committed beats {last,data}, beats of the open packet, discard mode, expected error pulse.
  logic [DW:0]   cq[$];
  logic [DW-1:0] pq[$];
  bit            m_discard = 1'b0;
  bit            m_werr    = 1'b0;

  always #5 clk = ~clk;

  libhdl_fifo_pkt #(
    .DATA_LEN(DW), .DEPTH(DEP), .ALMOST_EMPTY_CNT(AEC), .ALMOST_FULL_CNT(AFC)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .o_wrdy(o_wrdy), .i_wvld(wvld), .i_wdat(wdat), .i_wlast(wlast), .i_wdrop(wdrop),
    .o_wfull(o_wfull), .o_walmost_full(o_walmost_full), .o_wcount(o_wcount), .o_werr(o_werr),
    .i_rrdy(rrdy), .o_rvld(o_rvld), .o_rdat(o_rdat), .o_rlast(o_rlast),
    .o_rempty(o_rempty), .o_ralmost_empty(o_ralmost_empty), .o_rcount(o_rcount), .o_pkt_cnt(o_pkt_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_pkts();
    int n = 0;
    foreach (cq[i]) if (cq[i][DW]) n++;
    return n;
  endfunction

  function automatic bit m_overflow();
`ifdef LIBHDL_FIFO_PKT_DROP_EN
    return !m_discard && (pq.size() == DEP) && (cq.size() == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_wrdy();
    if (m_discard || m_overflow()) return 1'b1;
    return (cq.size() + pq.size()) < DEP;
  endfunction

  task automatic check_outputs();
    int wc = cq.size() + pq.size();
    int rc = cq.size();
    check("wrdy", o_wrdy, m_wrdy());
    check("rvld", o_rvld, rc != 0);
    check("wfull", o_wfull, wc == DEP);
    check("walmost_full", o_walmost_full, wc >= AFC);
    check("wcount", o_wcount, wc);
    check("rempty", o_rempty, rc == 0);
    check("ralmost_empty", o_ralmost_empty, rc <= AEC);
    check("rcount", o_rcount, rc);
    check("pkt_cnt", o_pkt_cnt, m_pkts());
    check("werr", o_werr, m_werr);
    if (rc != 0) begin
      check("rdat", o_rdat, cq[0][DW-1:0]);
      check("rlast", o_rlast, cq[0][DW]);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wrdy"}, o_wrdy, 0);
    check({tag, "_rvld"}, o_rvld, 0);
    check({tag, "_wfull"}, o_wfull, 0);
    check({tag, "_walmost_full"}, o_walmost_full, 0);
    check({tag, "_wcount"}, o_wcount, 0);
    check({tag, "_werr"}, o_werr, 0);
    check({tag, "_rempty"}, o_rempty, 1);
    check({tag, "_ralmost_empty"}, o_ralmost_empty, 1);
    check({tag, "_rcount"}, o_rcount, 0);
    check({tag, "_pkt_cnt"}, o_pkt_cnt, 0);
  endtask

  // One clock cycle, entered and left just after the falling edge.
  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic wl,
                      input logic wdp, input logic rr);
    bit wacc, racc, ovf;
    wvld = wv; wdat = wd; wlast = wl; wdrop = wdp; rrdy = rr;
    #1;
    check_outputs();
    wacc = wv && m_wrdy();
    racc = rr && (cq.size() != 0);
    ovf  = m_overflow();
    @(posedge clk);
    m_werr = 1'b0;
    if (racc) void'(cq.pop_front());
    if (m_discard) begin
      if (wdp) m_discard = 1'b0;
      else if (wacc && wl) begin
        m_werr    = 1'b1;
        m_discard = 1'b0;
      end
    end else if (wdp) begin
      pq.delete();
    end else if (ovf) begin
      pq.delete();
      if (wacc && wl) m_werr = 1'b1;
      else            m_discard = 1'b1;
    end else if (wacc) begin
      if (wl) begin
        foreach (pq[i]) cq.push_back({1'b0, pq[i]});
        cq.push_back({1'b1, wd});
        pq.delete();
      end else begin
        pq.push_back(wd);
      end
    end
    @(negedge clk);
    wvld = 1'b0; wlast = 1'b0; wdrop = 1'b0; rrdy = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 * DEP && cq.size() != 0; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    #1;
    check({tag, "_drained_rvld"}, o_rvld, 0);
  endtask

  initial begin
    int pulses;
    // Reset state, held over several edges.
    #1;
    check_reset("por");
    @(negedge clk);
    check_reset("por_hold");
    @(negedge clk);
    rst = 1'b0;

    // 3-beat packet only readable after its last beat.
    step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    check("rvld_before_last", o_rvld, 0);
    step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    #1;
    check("pkt_cnt_after_commit", o_pkt_cnt, 1);
    check("first_beat", o_rdat, 32'hA);
    drain("pkt3");
    check("pkt_cnt_after_read", o_pkt_cnt, 0);

    // Dropped partial packet never reaches the reader.
    step(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    #1;
    check("after_drop_rdat", o_rdat, 32'h55);
    check("after_drop_rlast", o_rlast, 1);
    drain("drop");
    check("drop_wcount", o_wcount, 0);

    // Fill with four 4-beat packets, then one read reopens the write side.
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 4; b++) step(1'b1, 32'h100 + p * 16 + b, b == 3, 1'b0, 1'b0);
    #1;
    check("full_wfull", o_wfull, 1);
    check("full_wrdy", o_wrdy, 0);
    check("full_walmost_full", o_walmost_full, 1);
    check("full_pkt_cnt", o_pkt_cnt, 4);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    #1;
    check("wrdy_after_read", o_wrdy, 1);
    drain("full");

    // Commit of one packet coinciding with consumption of another packet's last beat.
    step(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h21, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b1, 1'b0, 1'b1);
    #1;
    check("simul_pkt_cnt", o_pkt_cnt, 1);
    drain("simul");

    // 20-beat packet into an empty FIFO.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h200 + i, i == 19, 1'b0, 1'b0);
      pulses += int'(o_werr);
    end
`ifdef LIBHDL_FIFO_PKT_DROP_EN
    check("oversize_rvld", o_rvld, 0);
`else
    check("oversize_wrdy", o_wrdy, 0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
`endif
    step(1'b1, 32'h301, 1'b0, 1'b0, 1'b0);
    pulses += int'(o_werr);
    step(1'b1, 32'h302, 1'b1, 1'b0, 1'b0);
    pulses += int'(o_werr);
`ifdef LIBHDL_FIFO_PKT_DROP_EN
    check("oversize_werr_pulses", pulses, 1);
`else
    check("oversize_werr_pulses", pulses, 0);
`endif
    #1;
    check("after_oversize_rdat", o_rdat, 32'h301);
    check("after_oversize_pkts", o_pkt_cnt, 1);
    drain("oversize");

    // Reset mid-packet with two packets stored.
    step(1'b1, 32'h401, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h402, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h403, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    cq.delete(); pq.delete(); m_discard = 1'b0; m_werr = 1'b0;
    step(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    #1;
    check("post_rst_rdat", o_rdat, 32'h77);
    drain("post_rst");

    // Random traffic.
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/libhdl_fifo_pkt.md
# libhdl_fifo_pkt

Common-clock packet FIFO: a parametrised successor of the libhdl FIFO family with end-of-packet framing. Beats are written speculatively and become visible to the reader only when the packet's last beat is committed. Packets can be discarded mid-stream, so downstream logic only ever sees complete packets. It sits between packet producers (MAC/parser stages) and consumers that must not start on partial frames.

## Interface
- DATA_LEN, 32, payload width in bits
- DEPTH, 16, storage depth in beats; power of two, >= 4; AW = $clog2(DEPTH)
- ALMOST_EMPTY_CNT, DEPTH/4, o_ralmost_empty threshold (committed beats)
- ALMOST_FULL_CNT, DEPTH-DEPTH/4, o_walmost_full threshold (all stored beats)

Ports:
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- o_wrdy  out  1  write side can accept a beat
- i_wvld  in  1  write beat valid
- i_wdat  in  DATA_LEN  write payload
- i_wlast  in  1  beat is last of packet (commit)
- i_wdrop  in  1  discard current uncommitted packet
- o_wfull  out  1  DEPTH beats stored (committed + uncommitted)
- o_walmost_full  out  1  o_wcount >= ALMOST_FULL_CNT
- o_wcount  out  AW+1  wr_ptr - rd_ptr
- o_werr  out  1  one-cycle pulse: oversize packet was discarded
- i_rrdy  in  1  reader accepts beat
- o_rvld  out  1  committed beat available
- o_rdat  out  DATA_LEN  read payload (first-word fall-through)
- o_rlast  out  1  o_rdat is last beat of packet
- o_rempty  out  1  o_rcount == 0
- o_ralmost_empty  out  1  o_rcount <= ALMOST_EMPTY_CNT
- o_rcount  out  AW+1  commit_ptr - rd_ptr
- o_pkt_cnt  out  AW+1  committed, not fully read packets

## Operation
- Three AW+1-bit pointers: wr_ptr (speculative), commit_ptr, rd_ptr; all arithmetic modulo 2^(AW+1), extra MSB distinguishes full from empty.
- Memory is DEPTH x (DATA_LEN+1); the extra bit stores i_wlast. Asynchronous read at rd_ptr[AW-1:0].
- Write handshake: beat accepted when i_wvld && o_wrdy at the clock edge; stored at wr_ptr; wr_ptr++.
- o_wrdy = !o_wfull && !i_rst (registered state only, no same-cycle read pass-through).
- Accepted beat with i_wlast: commit_ptr <= wr_ptr + 1; o_pkt_cnt++.
- i_wdrop high in any cycle: wr_ptr <= commit_ptr; a beat accepted in the same cycle is discarded, and drop wins over i_wlast (no commit).
- Read handshake: beat consumed when o_rvld && i_rrdy; rd_ptr++. o_rvld = (rd_ptr != commit_ptr).
- Consuming a beat with o_rlast decrements o_pkt_cnt; a simultaneous commit leaves it unchanged.
- Write FSM: W_PASS (normal), W_DISCARD (see Configuration). Reset state W_PASS.
- Reset mid-packet: all pointers, counters and FSM return to reset; stored and uncommitted data are lost.

## Timing
- Reset values: o_wrdy 0 during i_rst, 1 after release; o_rvld 0; o_wfull 0; o_walmost_full 0; o_wcount 0; o_werr 0; o_rempty 1; o_ralmost_empty 1; o_rcount 0; o_pkt_cnt 0; o_rdat/o_rlast don't-care while o_rvld low.
- Commit-to-read latency: last beat accepted at edge N, so o_rvld is high from edge N; the first read can complete at edge N+1.
- Full: a read at edge N raises o_wrdy after edge N; the write is accepted at N+1 at the earliest.
- All status outputs derive from registered pointers; no combinational path from i_wvld/i_rrdy to o_wrdy/o_rvld.

## Configuration
- LIBHDL_FIFO_PKT_DROP_EN defined: oversize packet handling enabled.
  - When o_wfull and commit_ptr == rd_ptr (the FIFO is full of one uncommitted packet), o_wrdy is forced to 1 and the FSM enters W_DISCARD with wr_ptr <= commit_ptr.
  - In W_DISCARD, beats are accepted and thrown away until the beat with i_wlast; on that beat o_werr pulses one cycle and the FSM returns to W_PASS.
  - i_wdrop in W_DISCARD returns the FSM to W_PASS without o_werr.
- Not defined: no W_DISCARD state; o_werr tied 0. A packet longer than DEPTH deadlocks the write side, and avoiding this is the producer's responsibility.

## Test plan
- Write 3-beat packet 0xA,0xB,0xC (last on 0xC) -> o_rvld stays 0 until 0xC is accepted, then 0xA/0xB/0xC are read with o_rlast only on 0xC; o_pkt_cnt goes 1 -> 0.
- Write 2 beats, then assert i_wdrop, then write a 1-beat packet 0x55 -> reader sees only 0x55; o_wcount returns to 0 after the read.
- Fill with four 4-beat packets (DEPTH=16) -> o_wfull=1, o_wrdy=0, o_walmost_full=1, o_pkt_cnt=4; one read -> o_wrdy=1 next cycle.
- Commit a last beat in the same cycle the reader consumes a different packet's last beat -> o_pkt_cnt unchanged.
- With LIBHDL_FIFO_PKT_DROP_EN, write a 20-beat packet into an empty FIFO -> no beats visible, o_werr pulses once on beat 20, a following 2-beat packet reads out intact; without the macro, o_wrdy=0 after 16 beats.
- Assert i_rst mid-packet with 2 packets stored -> all outputs at reset values immediately; the next packet reads out correctly.
